multiword_addsub_seq: RTL and testbench
=======================================

Name: multiword_addsub_seq

Overview:
- Upstream sequencer for the 32-bit combinational add/sub unit (`bit32`).
- Splits wide operands into 32-bit limbs and drives the unit one limb per clock, LSB first.
- Chains carry/borrow between limbs and assembles the wide result plus N/Z/V/C status.
- Provides a valid/ready result interface to downstream logic.

Parameters:
- WORDS, 4, number of 32-bit limbs; operand width W = 32*WORDS; legal range 1..16.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted when start && in_ready at a clk edge.
- in_ready  out  1  = (state==IDLE) || (state==DONE && out_ready).
- op  in  1  0 = add, 1 = subtract; sampled on accept.
- opa  in  W  operand A; sampled on accept.
- opb  in  W  operand B; sampled on accept.
- carry_in  in  1  carry (add) or borrow (sub) into limb 0; sampled on accept.
- busy  out  1  high in RUN.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  W  wide sum/difference.
- carry_out  out  1  final carry (add) or final borrow (sub).
- zero  out  1  all W result bits zero.
- overflow  out  1  signed overflow of the W-bit operation (top limb's overflow).
- negative  out  1  result[W-1].
- add_a  out  32  limb of A driven to the adder.
- add_b  out  32  limb of B driven to the adder.
- add_sel  out  2  01 add, 10 sub, 00 idle.
- add_cin  out  1  adder carry-in.
- add_bin  out  1  adder borrow-in.
- add_z  in  32  adder result.
- add_cout  in  1  adder carry-out.
- add_bout  in  1  adder borrow-out.
- add_overflow  in  1  adder signed overflow.
- add_negative  in  1  adder sign.

Behaviour:
- Clocking and reset: one clock, synchronous active-high reset.
- Reset values: state=IDLE, busy=0, out_valid=0, result=0, carry_out=0, zero=0, overflow=0, negative=0, limb index=0, operand/op registers=0.
- States: IDLE, RUN, DONE.
- IDLE --accept--> RUN.
  - Latch op, opa, opb, carry_in.
  - idx=0; running-zero flag=1.
- RUN: adder ports are combinational from registers.
  - add_a = A[32*idx+:32], add_b = B[32*idx+:32].
  - add_sel = op ? 10 : 01.
  - Carry into each limb: limb 0 uses latched carry_in; later limbs use the registered previous add_cout (add) / add_bout (sub).
  - Add: drive that carry on add_cin; add_bin=0. Sub: drive it on add_bin; add_cin=0.
- Each RUN edge:
  - result[32*idx+:32] <= add_z.
  - Chain register <= add_cout/add_bout.
  - Running-zero &= (add_z==0).
  - idx++.
- At the edge where idx==WORDS-1:
  - carry_out <= chain value; overflow <= add_overflow; negative <= add_negative; zero <= final running-zero.
  - Go to DONE.
- Latency: out_valid rises exactly WORDS cycles after the accept edge. One op per WORDS+1 cycles at best; back-to-back via DONE acceptance.
- DONE:
  - out_valid=1; result and flags held stable while out_ready=0.
  - out_ready && !start → IDLE.
  - out_ready && start → accept the new op, go to RUN; out_valid low next cycle.
- Outside RUN: add_sel=00, add_a=add_b=0, add_cin=add_bin=0.
- start while in RUN, or while in DONE with out_ready=0: ignored, not queued.
- Operand inputs outside an accept edge: no effect.
- rst asserted in any state (including mid-RUN): next edge returns to reset values; the partial result is discarded.
- WORDS=1: RUN lasts one cycle; behaves as the registered single-word unit.

Optional Feature:
- MWAS_STICKY_OVF_EN defined:
  - Adds ports sticky_ovf (out, 1) and sticky_clr (in, 1).
  - sticky_ovf sets on entry to DONE with overflow=1.
  - It clears on sticky_clr or rst. Clear wins if clear and set occur in the same cycle.
  - Reset value 0.
- Undefined: neither port exists; no extra logic.

Test Plan (WORDS=4):
- Add across a limb: opa=0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, opb=1, carry_in=0 → result=0x0000_0000_0000_0001_0000_0000_0000_0000, C=0, Z=0, V=0, N=0; out_valid exactly 4 cycles after accept; add_sel=01 for those 4 cycles.
- Add wrap: opa=all-ones, opb=0, carry_in=1 → result=0, carry_out=1, zero=1, overflow=0, negative=0.
- Subtract negative: opa=0, opb=1, carry_in=0 → result=all-ones, carry_out(borrow)=1, negative=1, overflow=0; add_bin=1 on limbs 1..3.
- Subtract overflow: opa=0x8000_0000_0000_0000_0000_0000_0000_0000, opb=1 → result=0x7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, overflow=1, negative=0, borrow=0. With MWAS_STICKY_OVF_EN, sticky_ovf=1 until sticky_clr.
- Reset/ignore:
  - start asserted during RUN is ignored; busy stays 1 and the original result is produced.
  - rst asserted after 2 RUN cycles → next cycle busy=0, out_valid=0, result=0, add_sel=00.
- Backpressure: out_ready=0 for 10 cycles → result/flags stable, in_ready=0. Then out_ready=1 with start=1 → new op accepted same edge, out_valid=0 next cycle, new result 4 cycles later.

Source files
------------

// File: rtl/multiword_addsub_seq.sv
// Sequences a wide add/subtract through an external 32-bit add/sub unit, one limb per clock, LSB first.
// Optional sticky overflow flag is enabled by defining MWAS_STICKY_OVF_EN.
module multiword_addsub_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  in_ready,
  input  logic                  op,
  input  logic [32*WORDS-1:0]   opa,
  input  logic [32*WORDS-1:0]   opb,
  input  logic                  carry_in,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WORDS-1:0]   result,
  output logic                  carry_out,
  output logic                  zero,
  output logic                  overflow,
  output logic                  negative,
`ifdef MWAS_STICKY_OVF_EN
  output logic                  sticky_ovf,
  input  logic                  sticky_clr,
`endif
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic [1:0]            add_sel,
  output logic                  add_cin,
  output logic                  add_bin,
  input  logic [31:0]           add_z,
  input  logic                  add_cout,
  input  logic                  add_bout,
  input  logic                  add_overflow,
  input  logic                  add_negative
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_reg;
  logic                  op_reg;
  logic                  chain_reg;
  logic                  zrun_reg;
  logic [IW-1:0]         idx_reg;
  logic [32*WORDS-1:0]   a_reg;
  logic [32*WORDS-1:0]   b_reg;
  logic                  carry_out_reg;
  logic                  zero_reg;
  logic                  overflow_reg;
  logic                  negative_reg;

  logic [31:0]           a_limb [WORDS];
  logic [31:0]           b_limb [WORDS];
  logic                  running;
  logic                  last_limb;
  logic                  accept;
  logic                  limb_carry;
  logic                  limb_zero;

  assign running    = (state_reg == RUN);
  assign last_limb  = running && (idx_reg == IW'(WORDS - 1));
  assign in_ready   = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign accept     = start && in_ready;
  assign limb_carry = op_reg ? add_bout : add_cout;
  assign limb_zero  = (add_z == 32'd0);

  // Each limb of the result owns its register; only the limb under idx_reg is written in RUN.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_limb
      logic [31:0] limb_reg;

      assign a_limb[gi] = a_reg[32*gi +: 32];
      assign b_limb[gi] = b_reg[32*gi +: 32];
      assign result[32*gi +: 32] = limb_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          limb_reg <= 32'd0;
        end else if (running && (idx_reg == IW'(gi))) begin
          limb_reg <= add_z;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      op_reg        <= 1'b0;
      chain_reg     <= 1'b0;
      zrun_reg      <= 1'b0;
      idx_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      carry_out_reg <= 1'b0;
      zero_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      negative_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          chain_reg <= limb_carry;
          zrun_reg  <= zrun_reg & limb_zero;
          idx_reg   <= idx_reg + 1'b1;
          if (last_limb) begin
            carry_out_reg <= limb_carry;
            overflow_reg  <= add_overflow;
            negative_reg  <= add_negative;
            zero_reg      <= zrun_reg & limb_zero;
            idx_reg       <= '0;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: ;
      endcase
      // Acceptance only happens in IDLE or DONE, so it overrides the transitions above.
      if (accept) begin
        op_reg    <= op;
        a_reg     <= opa;
        b_reg     <= opb;
        chain_reg <= carry_in;
        zrun_reg  <= 1'b1;
        idx_reg   <= '0;
        state_reg <= RUN;
      end
    end
  end

  assign busy      = running;
  assign out_valid = (state_reg == DONE);
  assign carry_out = carry_out_reg;
  assign zero      = zero_reg;
  assign overflow  = overflow_reg;
  assign negative  = negative_reg;

  // Limb 0's carry is the latched carry_in, parked in chain_reg at accept.
  assign add_a   = running ? a_limb[idx_reg] : 32'd0;
  assign add_b   = running ? b_limb[idx_reg] : 32'd0;
  assign add_sel = running ? (op_reg ? 2'b10 : 2'b01) : 2'b00;
  assign add_cin = running && !op_reg && chain_reg;
  assign add_bin = running && op_reg && chain_reg;

`ifdef MWAS_STICKY_OVF_EN
  logic sticky_reg;

  always_ff @(posedge clk) begin
    if (rst || sticky_clr) begin
      sticky_reg <= 1'b0;
    end else if (last_limb && add_overflow) begin
      sticky_reg <= 1'b1;
    end
  end

  assign sticky_ovf = sticky_reg;
`endif

endmodule

// File: tb/tb_multiword_addsub_seq.sv
// Directed and random checks of multiword_addsub_seq (WORDS=4) against a wide-arithmetic reference,
// with a behavioural 32-bit add/sub unit attached to the limb ports.
module tb_multiword_addsub_seq;

  localparam int WORDS = 4;
  localparam int W = 32 * WORDS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_ready;
  logic          op = 1'b0;
  logic [W-1:0]  opa = '0;
  logic [W-1:0]  opb = '0;
  logic          carry_in = 1'b0;
  logic          busy;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic          carry_out;
  logic          zero;
  logic          overflow;
  logic          negative;
`ifdef MWAS_STICKY_OVF_EN
  logic          sticky_ovf;
  logic          sticky_clr = 1'b0;
`endif
  logic [31:0]   add_a;
  logic [31:0]   add_b;
  logic [1:0]    add_sel;
  logic          add_cin;
  logic          add_bin;
  logic [31:0]   add_z;
  logic          add_cout;
  logic          add_bout;
  logic          add_overflow;
  logic          add_negative;

  int            checks = 0;
  int            passed = 0;
  int            lat;
  logic [1:0]    sel_log [4];
  logic          bin_log [4];
  logic          cin_log [4];

  multiword_addsub_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .in_ready(in_ready), .op(op),
    .opa(opa), .opb(opb), .carry_in(carry_in), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry_out(carry_out), .zero(zero),
    .overflow(overflow), .negative(negative),
`ifdef MWAS_STICKY_OVF_EN
    .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr),
`endif
    .add_a(add_a), .add_b(add_b), .add_sel(add_sel), .add_cin(add_cin),
    .add_bin(add_bin), .add_z(add_z), .add_cout(add_cout), .add_bout(add_bout),
    .add_overflow(add_overflow), .add_negative(add_negative)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the external 32-bit add/sub unit.
  logic [32:0] t33;
  always_comb begin
    t33 = 33'd0;
    case (add_sel)
      2'b01:   t33 = {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);
      2'b10:   t33 = {1'b0, add_a} - {1'b0, add_b} - 33'(add_bin);
      default: t33 = 33'd0;
    endcase
    add_z        = t33[31:0];
    add_cout     = (add_sel == 2'b01) && t33[32];
    add_bout     = (add_sel == 2'b10) && t33[32];
    add_negative = t33[31];
    add_overflow = 1'b0;
    if (add_sel == 2'b01) add_overflow = (add_a[31] == add_b[31]) && (t33[31] != add_a[31]);
    if (add_sel == 2'b10) add_overflow = (add_a[31] != add_b[31]) && (t33[31] != add_a[31]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    assert (act === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, act, exp);
  endtask

  function automatic logic [W-1:0] rand_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: the whole operation as one wide unsigned and one sign-extended computation.
  function automatic void ref_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, output logic [W-1:0] r, output logic co,
                                 output logic z, output logic v, output logic n);
    logic [W:0]   u;
    logic [W+1:0] s;
    if (o) begin
      u = {1'b0, a} - {1'b0, b} - (W+1)'(c);
      s = {{2{a[W-1]}}, a} - {{2{b[W-1]}}, b} - (W+2)'(c);
    end else begin
      u = {1'b0, a} + {1'b0, b} + (W+1)'(c);
      s = {{2{a[W-1]}}, a} + {{2{b[W-1]}}, b} + (W+2)'(c);
    end
    r  = u[W-1:0];
    co = u[W];
    z  = (r == '0);
    v  = (s[W] != s[W-1]);
    n  = r[W-1];
  endfunction

  // Drive one request through the accept edge, then scramble the operand inputs.
  task automatic launch(input logic o, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    op = o; opa = a; opb = b; carry_in = c; start = 1'b1;
    tick();
    start = 1'b0;
    opa = rand_w(); opb = rand_w();
    op = 1'($urandom_range(0, 1)); carry_in = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid();
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (lat < 4) begin
        sel_log[lat] = add_sel; bin_log[lat] = add_bin; cin_log[lat] = add_cin;
      end
      tick();
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic o, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic c, input int exp_lat);
    logic [W-1:0] r;
    logic co, z, v, n;
    ref_op(o, a, b, c, r, co, z, v, n);
    chk({tag, ".lat"}, W'(lat), W'(exp_lat));
    chk({tag, ".result"}, result, r);
    chk({tag, ".carry"}, W'(carry_out), W'(co));
    chk({tag, ".zero"}, W'(zero), W'(z));
    chk({tag, ".ovf"}, W'(overflow), W'(v));
    chk({tag, ".neg"}, W'(negative), W'(n));
    $display("op=%0d a=%h b=%h c=%0d -> result=%h C=%0d Z=%0d V=%0d N=%0d lat=%0d",
             o, a, b, c, result, carry_out, zero, overflow, negative, lat);
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] held;
    logic [W-1:0] na, nb;
    logic         ro, rc;
    ones = '1;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst.busy", W'(busy), W'(1'b0));
    chk("rst.valid", W'(out_valid), W'(1'b0));
    chk("rst.result", result, '0);
    chk("rst.sel", W'(add_sel), W'(2'b00));
    chk("rst.in_ready", W'(in_ready), W'(1'b1));
    chk("rst.flags", W'({carry_out, zero, overflow, negative}), W'(4'b0000));

    // Add across a limb boundary
    launch(1'b0, {64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, W'(1), 1'b0);
    wait_valid();
    check_result("add_limb", 1'b0, {64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, W'(1), 1'b0, 4);
    chk("add_limb.exp", result, {64'd1, 64'd0});
    for (int i = 0; i < 4; i++) chk("add_limb.sel", W'(sel_log[i]), W'(2'b01));

    // Add wrap with carry in
    launch(1'b0, ones, '0, 1'b1);
    wait_valid();
    check_result("add_wrap", 1'b0, ones, '0, 1'b1, 4);
    chk("add_wrap.zc", W'({zero, carry_out}), W'(2'b11));

    // Subtract to negative: borrow ripples into limbs 1..3
    launch(1'b1, '0, W'(1), 1'b0);
    wait_valid();
    check_result("sub_neg", 1'b1, '0, W'(1), 1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("sub_neg.sel", W'(sel_log[i]), W'(2'b10));
      chk("sub_neg.bin", W'(bin_log[i]), W'(i != 0));
      chk("sub_neg.cin", W'(cin_log[i]), W'(1'b0));
    end

    // Subtract with signed overflow
    launch(1'b1, {1'b1, 127'd0}, W'(1), 1'b0);
    wait_valid();
    check_result("sub_ovf", 1'b1, {1'b1, 127'd0}, W'(1), 1'b0, 4);
    chk("sub_ovf.exp", result, {1'b0, {127{1'b1}}});
`ifdef MWAS_STICKY_OVF_EN
    tick(); tick();
    chk("sticky.set", W'(sticky_ovf), W'(1'b1));
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("sticky.clr", W'(sticky_ovf), W'(1'b0));
`endif

    // start during RUN is ignored
    na = rand_w(); nb = rand_w();
    launch(1'b0, na, nb, 1'b0);
    start = 1'b1; opa = rand_w(); opb = rand_w();
    tick();
    chk("ign.busy", W'(busy), W'(1'b1));
    start = 1'b0;
    wait_valid();
    check_result("ign", 1'b0, na, nb, 1'b0, 3);

    // Reset in the middle of RUN
    launch(1'b0, rand_w(), rand_w(), 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst.busy", W'(busy), W'(1'b0));
    chk("mrst.valid", W'(out_valid), W'(1'b0));
    chk("mrst.result", result, '0);
    chk("mrst.sel", W'(add_sel), W'(2'b00));

    // Backpressure, then accept from DONE on the releasing edge
    out_ready = 1'b0;
    na = rand_w(); nb = rand_w();
    launch(1'b1, na, nb, 1'b1);
    wait_valid();
    check_result("bp", 1'b1, na, nb, 1'b1, 4);
    held = result;
    na = rand_w(); nb = rand_w();
    op = 1'b0; opa = na; opb = nb; carry_in = 1'b0; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp.stable", result, held);
      chk("bp.valid", W'(out_valid), W'(1'b1));
      chk("bp.in_ready", W'(in_ready), W'(1'b0));
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", W'(in_ready), W'(1'b1));
    tick();
    start = 1'b0;
    chk("bp.valid_drop", W'(out_valid), W'(1'b0));
    chk("bp.busy", W'(busy), W'(1'b1));
    wait_valid();
    check_result("bp.next", 1'b0, na, nb, 1'b0, 4);

    // Randomized operations against the reference
    for (int k = 0; k < 24; k++) begin
      na = rand_w(); nb = rand_w();
      ro = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      if (k % 6 == 0) nb = na;
      launch(ro, na, nb, rc);
      wait_valid();
      check_result("rand", ro, na, nb, rc, 4);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
